// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 encryption round engine:
//   NR        - number of rounds (AES-128 only)
//   fsm_t     - controller states IDLE / ROUND / DONE
//   byte_msb  - top bit of state byte (row r, column c) in the 128-bit word
//   xtime     - multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1
//   mix_col   - MixColumns applied to one 32-bit column (row 0 in [31:24])
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // Byte i of the state sits at bits [127-8i -: 8], and (r, c) is byte 4c+r.
  function automatic int byte_msb(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 3*a is expressed as xtime(a) ^ a.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/shift_mix.sv
// ---------------------------------------------------------------------------
// shift_mix
// Combinational ShiftRows followed by MixColumns. The final AES round has no
// MixColumns, so bypass_mix returns the ShiftRows result alone.
// Ports:
//   in         [127:0] input   state after SubBytes
//   bypass_mix          input   1 = skip MixColumns (last round)
//   out        [127:0] output  ShiftRows (and optionally MixColumns) result
// ---------------------------------------------------------------------------
module shift_mix
  import aes_pkg::*;
(
  input  logic [127:0] in,
  input  logic         bypass_mix,
  output logic [127:0] out
);

  logic [127:0] shifted;
  logic [127:0] mixed;

  // Row r rotates left by r columns: out(r,c) takes in(r,(c+r) mod 4).
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign shifted[byte_msb(r, c) -: 8] = in[byte_msb(r, (c + r) % 4) -: 8];
    end
  end

  // Each column is a contiguous 32-bit slice, column 0 at the top.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[127 - 32 * c -: 32] = mix_col(shifted[127 - 32 * c -: 32]);
  end

  assign out = bypass_mix ? shifted : mixed;

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_enc_round_ctrl
// Iterative AES-128 encryption engine, one round per clock. Owns the state
// register, feeds it to an external combinational SubBytes stage, and folds
// ShiftRows / MixColumns / AddRoundKey back into the register each cycle.
// Round keys come from an external key store addressed by rk_idx.
// Ports:
//   clk                clock, rising edge
//   rst                synchronous active-high reset
//   in_valid / in_ready  plaintext handshake (accepted only in IDLE)
//   pt        [127:0]  plaintext, FIPS byte 0 = pt[127:120]
//   out_valid / out_ready ciphertext handshake
//   ct        [127:0]  ciphertext, straight from the state register
//   rk_idx    [3:0]    requested round-key index (0..10)
//   rk        [127:0]  round key for rk_idx, same cycle
//   sb_in     [127:0]  state register to SubBytes
//   sb_out    [127:0]  SubBytes result, consumed in the same cycle
// ---------------------------------------------------------------------------
module aes_enc_round_ctrl #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] sb_in,
  input  logic [127:0] sb_out
);

  import aes_pkg::*;

  // Only the AES-128 schedule is implemented; refuse to elaborate otherwise.
  if (NR != 10) begin : g_bad_nr
    $error("aes_enc_round_ctrl supports only NR = 10");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] round_out;

  assign sb_in = state_q;
  assign ct    = state_q;

  // The last round skips MixColumns.
  shift_mix u_shift_mix (
    .in         (sb_out),
    .bypass_mix (rnd_q == LAST_RND),
    .out        (round_out)
  );

  // State, round counter and FSM all clear together on reset, so a reset in
  // the middle of a block leaves nothing behind on ct or out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // Next-state and handshake logic. IDLE does the initial AddRoundKey with
  // key 0, ROUND walks keys 1..10, DONE holds the result until taken. A new
  // plaintext is never accepted in the same cycle DONE is released.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'd0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = pt ^ rk;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rk_idx  = rnd_q;
        state_d = round_out ^ rk;
        if (rnd_q >= LAST_RND) begin
          rnd_d = 4'd0;
          fsm_d = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
        rnd_d = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_enc_round_ctrl
// Self-checking bench for aes_enc_round_ctrl. Supplies a SubBytes table and a
// round-key store built from first principles (GF(2^8) inverse + affine map,
// FIPS-197 key expansion) and compares against FIPS-197 vectors and a
// byte-array AES reference model for random vectors.
// ---------------------------------------------------------------------------
module tb_aes_enc_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] sb_in;
  logic [127:0] sb_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox       [256];
  logic [127:0] round_keys [16];

  aes_enc_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct        (ct),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .sb_in     (sb_in),
    .sb_out    (sb_out)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Key store returns the round key combinationally.
  assign rk = round_keys[rk_idx];

  // External SubBytes stage, one table lookup per byte.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sb_out[127 - 8 * i -: 8] = sbox[sb_in[127 - 8 * i -: 8]];
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [7:0] getByte(input logic [127:0] v, input int i);
    return 8'(v >> (8 * (15 - i)));
  endfunction

  task automatic buildSbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb  = 8'(x);
      logic [7:0] inv = 8'h00;
      logic [7:0] b1, b2, b3, b4;
      for (int y = 1; y < 256; y++) begin
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      end
      b1 = rotl8(inv);
      b2 = rotl8(b1);
      b3 = rotl8(b2);
      b4 = rotl8(b3);
      sbox[xb] = inv ^ b1 ^ b2 ^ b3 ^ b4 ^ 8'h63;
    end
  endtask

  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = 32'(key >> (32 * (3 - i)));
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 16; r++) round_keys[r] = '0;
    for (int r = 0; r <= 10; r++) round_keys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] modelEncrypt(input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) s[i] = getByte(p, i) ^ getByte(round_keys[0], i);
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r + 4 * c] = s[r + 4 * ((c + r) % 4)];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
          s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] ^= getByte(round_keys[rd], i);
    end
    for (int i = 0; i < 16; i++) v = {v[119:0], s[i]};
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Offers p, waits (bounded) for the accept, then follows all ten rounds and
  // ends on the first DONE cycle with the ciphertext checked.
  task automatic applyStimulus(input logic [127:0] p, input logic [127:0] exp_ct,
                               input string tag, input bit busy_pulse,
                               input bit check_sb1, input logic [127:0] exp_sb1);
    int waited = 0;
    pt       = p;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_accept_ready"}, 128'(in_ready), 128'd1);
    checkOutput({tag, "_idle_rk_idx"}, 128'(rk_idx), 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    if (check_sb1) checkOutput({tag, "_sb_in_round1"}, sb_in, exp_sb1);
    for (int k = 1; k <= 10; k++) begin
      checkOutput($sformatf("%s_rk_idx_%0d", tag, k), 128'(rk_idx), 128'(k));
      checkOutput($sformatf("%s_busy_out_valid_%0d", tag, k), 128'(out_valid), 128'd0);
      checkOutput($sformatf("%s_busy_in_ready_%0d", tag, k), 128'(in_ready), 128'd0);
      if (busy_pulse) begin
        in_valid = (k >= 3 && k <= 6);
        pt       = ~p;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput({tag, "_done_out_valid"}, 128'(out_valid), 128'd1);
    checkOutput({tag, "_done_ct"}, ct, exp_ct);
    checkOutput({tag, "_done_rk_idx"}, 128'(rk_idx), 128'd0);
  endtask

  // Holds out_ready low for 'stall' cycles, then takes the result.
  task automatic releaseOutput(input string tag, input int stall, input logic [127:0] exp_ct);
    for (int i = 0; i < stall; i++) begin
      checkOutput($sformatf("%s_stall_out_valid_%0d", tag, i), 128'(out_valid), 128'd1);
      checkOutput($sformatf("%s_stall_ct_%0d", tag, i), ct, exp_ct);
      checkOutput($sformatf("%s_stall_in_ready_%0d", tag, i), 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_released_in_ready"}, 128'(in_ready), 128'd1);
    checkOutput({tag, "_released_out_valid"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] key_b = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] pt_b  = 128'h3243f6a8885a308d313198a2e0370734;
    logic [127:0] ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
    logic [127:0] sb1_b = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    logic [127:0] key_c = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] pt_c  = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] ct_c  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [127:0] pt_x, exp_x, key_r;
    int           waited;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pt        = '0;
    for (int i = 0; i < 16; i++) round_keys[i] = '0;
    buildSbox();

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 128'(in_ready), 128'd1);
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_ct", ct, 128'd0);
    checkOutput("reset_rk_idx", 128'(rk_idx), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 App. B with a 5-cycle output stall.
    expandKey(key_b);
    applyStimulus(pt_b, ct_b, "fips_b", 1'b0, 1'b1, sb1_b);
    releaseOutput("fips_b", 5, ct_b);

    // FIPS-197 App. C.1.
    expandKey(key_c);
    applyStimulus(pt_c, ct_c, "fips_c", 1'b0, 1'b0, '0);
    releaseOutput("fips_c", 0, ct_c);

    // in_valid pulsed with another plaintext during rounds 3..6.
    expandKey(key_b);
    applyStimulus(pt_b, ct_b, "busy", 1'b1, 1'b0, '0);
    releaseOutput("busy", 0, ct_b);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("busy_no_second_out_valid_%0d", i), 128'(out_valid), 128'd0);
      checkOutput($sformatf("busy_no_second_in_ready_%0d", i), 128'(in_ready), 128'd1);
      @(negedge clk);
    end

    // Reset while rnd = 5.
    pt       = pt_b;
    in_valid = 1'b1;
    checkOutput("rstmid_accept_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    waited   = 0;
    while (rk_idx != 4'd5 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rstmid_reached_rnd5", 128'(rk_idx), 128'd5);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rstmid_ct", ct, 128'd0);
    checkOutput("rstmid_in_ready", 128'(in_ready), 128'd1);
    checkOutput("rstmid_rk_idx", 128'(rk_idx), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    expandKey(key_c);
    applyStimulus(pt_c, ct_c, "after_rst", 1'b0, 1'b0, '0);
    releaseOutput("after_rst", 0, ct_c);

    // Back-to-back with in_valid and out_ready held high.
    pt_x      = {$urandom, $urandom, $urandom, $urandom};
    exp_x     = modelEncrypt(pt_x);
    pt        = pt_c;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    checkOutput("b2b_first_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    pt = pt_x;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("b2b_first_busy_%0d", k), 128'(out_valid), 128'd0);
      @(negedge clk);
    end
    checkOutput("b2b_first_out_valid", 128'(out_valid), 128'd1);
    checkOutput("b2b_first_ct", ct, ct_c);
    @(negedge clk);
    checkOutput("b2b_idle_in_ready", 128'(in_ready), 128'd1);
    checkOutput("b2b_idle_out_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    checkOutput("b2b_second_accepted", 128'(in_ready), 128'd0);
    checkOutput("b2b_second_rk_idx", 128'(rk_idx), 128'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("b2b_second_busy_%0d", k), 128'(out_valid), 128'd0);
      @(negedge clk);
    end
    checkOutput("b2b_second_out_valid", 128'(out_valid), 128'd1);
    checkOutput("b2b_second_ct", ct, exp_x);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("b2b_end_in_ready", 128'(in_ready), 128'd1);

    // Random keys and plaintexts against the reference model.
    for (int n = 0; n < 3; n++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom};
      pt_x  = {$urandom, $urandom, $urandom, $urandom};
      expandKey(key_r);
      exp_x = modelEncrypt(pt_x);
      applyStimulus(pt_x, exp_x, $sformatf("rand%0d", n), 1'b0, 1'b0, '0);
      releaseOutput($sformatf("rand%0d", n), int'($urandom_range(0, 3)), exp_x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
